ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-requester round-robin arbiter and sequencer in front of one `single_port_ram` (64 x 8, write on `clk` edge, registered read). After reset it zero-fills the whole array, then grants at most one access per cycle, so two independent masters can share the single port. Read data comes back to the requester through a per-requester response strobe.

## Interface
- `ADDR_WIDTH`, 6: RAM address width. Depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, 8: RAM word width.
- `clk` in 1: sole clock. All state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req0_valid` in 1: requester 0 has an access pending.
- `req0_we` in 1: 1 = write, 0 = read.
- `req0_addr` in ADDR_WIDTH: access address.
- `req0_wdata` in DATA_WIDTH: write data.
- `req0_ready` out 1: grant. The access completes on the edge where `req0_valid & req0_ready`.
- `rsp0_valid` out 1: read data for requester 0 is present this cycle.
- `rsp0_rdata` out DATA_WIDTH: read data; 0 whenever `rsp0_valid` = 0.
- `req1_*`, `rsp1_*`: same set for requester 1.
- `ram_data` out DATA_WIDTH: to RAM `data`.
- `ram_addr` out ADDR_WIDTH: to RAM `addr`.
- `ram_we` out 1: to RAM `we`.
- `ram_q` in DATA_WIDTH: from RAM `q`. It holds the word at the address presented on the previous edge.
- `init_done` out 1: zero-fill complete; arbitration active.

## Operation
- State machine: INIT -> ARB. There are no other states. `rst` forces INIT from any state.
- **INIT**
  - A counter `init_addr` steps from 0 to 2^ADDR_WIDTH-1.
  - RAM outputs are `ram_we`=1, `ram_addr`=`init_addr`, `ram_data`=0.
  - Both `reqN_ready` are 0.
  - On the edge that writes the last address, the block moves to ARB and `init_done` goes to 1.
- **ARB grant rule**
  - Grant is combinational from both `reqN_valid` and the registered priority pointer `prio` (0 or 1; reset value 0).
  - Only one requester valid: it is granted.
  - Both valid: requester `prio` is granted.
  - Neither valid: no grant. RAM outputs are `ram_we`=0, `ram_addr`=0, `ram_data`=0.
- **Pointer update**
  - On a completed grant to N, `prio` <= 1-N.
  - With no grant, `prio` holds.
  - A lone requester can therefore be granted every cycle.
- **Granted access**
  - RAM outputs are driven by the winner's we, addr and wdata.
  - A granted read sets the `read_pending` register and `owner` <= N.
  - In the next cycle `rspN_valid`=1 and `rspN_rdata`=`ram_q`.
  - A granted write produces no response.
- `reqN_ready` never depends on `rspN_*`. A new grant may overlap the previous read's response cycle.
- Request fields must stay stable while `reqN_valid`=1 and `reqN_ready`=0. Dropping `valid` before the grant withdraws the request without side effects.

## Timing
- Reset values:
  - state INIT, `init_addr`=0, `prio`=0, `read_pending`=0.
  - Outputs: `init_done`=0, `req0_ready`=`req1_ready`=0, `rsp0_valid`=`rsp1_valid`=0, `rspN_rdata`=0, `ram_we`=1, `ram_addr`=0, `ram_data`=0.
- Init length is exactly 2^ADDR_WIDTH cycles (64 with defaults). `init_done` rises on the 64th rising edge after `rst` deasserts.
- Read latency is 1: grant at edge k gives `rspN_valid` high for the cycle between edges k and k+1. One cycle exactly, no backpressure.
- Write takes effect at the grant edge. A read of the same address granted on the next cycle returns the new value.
- Throughput is one access per cycle. With both requesters valid continuously, grants strictly alternate 0,1,0,1...
- `rst` asserted mid-operation:
  - The pending response is dropped; `rspN_valid` goes low immediately (asynchronous).
  - The array is zero-filled again.
  - Requesters must re-issue any request that was not yet granted.
- `init_addr` does not wrap. The transition to ARB occurs at the terminal count.

## Structure
- A shared package holds:
  - the state enum {INIT, ARB};
  - defaults for `ADDR_WIDTH` and `DATA_WIDTH`;
  - the requester index constants `REQ0`=0 and `REQ1`=1.
- One sub-module is natural: `rr_grant2`, a combinational 2-way round-robin grant from valid[1:0] and `prio` to gnt[1:0].
- The arbiter top holds the FSM, the init counter, the pointer, the response tracking and the RAM mux. The RAM itself is instantiated only in the bench.

## Test plan
- **Reset and init:** assert then release `rst`. `ram_we`=1 with `ram_addr` 0..63, `ram_data`=0 throughout, `init_done`=1 after exactly 64 cycles. Then read 0x3F from req0: `rsp0_rdata`=0x00.
- **Single requester write/read:**
  - req0 writes 0x01@0, 0x02@1 and 0x03@3 on consecutive cycles, then reads @0, @1, @2.
  - Responses one cycle after each grant: 0x01, 0x02, 0x00.
  - `req0_ready` high every cycle.
- **Contention:** both valid for 4 cycles after init (`prio`=0). req0 writes 0xA5@5, req1 reads @5.
  - Grants go req0 first, then req1.
  - `rsp1_rdata`=0xA5.
  - Over the 4 cycles, `reqN_ready` alternates 0,1,0,1.
- **Overlap:** req0 read @1 at edge k, req1 write 0x77@1 at edge k+1, req0 read @1 at edge k+2.
  - `rsp0_rdata`=0x02 in cycle k+1.
  - `rsp0_rdata`=0x77 in cycle k+3.
  - `rsp1_valid` stays 0 throughout.
- **Reset mid-read:** assert `rst` in the cycle a read is granted.
  - `rsp0_valid` stays 0.
  - `init_done`=0, then the array is zeroed again: a subsequent read of @1 returns 0x00.
- **Withdrawn request:** req1 raises `valid` while req0 is granted, drops it before winning. No RAM access occurs for req1, `rsp1_valid`=0, and `prio` is unchanged by the withdrawal.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
// Shared definitions for the two-requester RAM port arbiter:
//   state_t        - sequencer states (INIT zero-fills the RAM, ARB arbitrates)
//   *_WIDTH_DEF    - default RAM geometry (64 x 8)
//   REQ0 / REQ1    - requester indices into the valid/grant vectors
package ram_port_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF = 6;
  localparam int DATA_WIDTH_DEF = 8;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

  typedef enum logic {
    INIT = 1'b0,
    ARB  = 1'b1
  } state_t;

endpackage

// File: rtl/ram_port_arbiter_rr_grant2.sv
// rr_grant2
// Combinational two-way round-robin grant.
//   valid[1:0] in  - request vector, bit N = requester N
//   prio       in  - requester that wins when both are valid
//   gnt[1:0]   out - one-hot grant (all zero when nothing is valid)
module rr_grant2
  import ram_port_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    // A lone requester always wins; prio only breaks ties.
    if (valid[REQ0] && (!valid[REQ1] || !prio)) begin
      gnt[REQ0] = 1'b1;
    end else if (valid[REQ1]) begin
      gnt[REQ1] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port RAM (write on clk edge, registered read) between
// two requesters. After reset the whole array is zero-filled, then at most
// one access per cycle is granted round-robin. Read data returns one cycle
// after the grant on the owning requester's response port.
//   req0_* / req1_*  - valid/we/addr/wdata in, ready (grant) out
//   rsp0_* / rsp1_*  - read response strobe and data (data 0 when idle)
//   ram_we/addr/data - RAM command outputs; ram_q - RAM read data input
//   init_done        - zero-fill finished, arbitration active
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  init_done
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  prio;
  logic                  read_pending;
  logic                  owner;
  logic [1:0]            gnt;
  logic                  arb;

  assign arb = (state == ARB);

  rr_grant2 u_grant (
    .valid ({req1_valid, req0_valid}),
    .prio  (prio),
    .gnt   (gnt)
  );

  assign req0_ready = arb & gnt[REQ0];
  assign req1_ready = arb & gnt[REQ1];

  // RAM command mux: zero-fill stream during INIT, winner's access in ARB,
  // all-zero idle command when nobody is granted.
  always_comb begin
    ram_we   = 1'b1;
    ram_addr = init_addr;
    ram_data = '0;
    if (arb) begin
      ram_we   = 1'b0;
      ram_addr = '0;
      if (req0_ready) begin
        ram_we   = req0_we;
        ram_addr = req0_addr;
        ram_data = req0_wdata;
      end else if (req1_ready) begin
        ram_we   = req1_we;
        ram_addr = req1_addr;
        ram_data = req1_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= INIT;
      init_addr    <= '0;
      init_done    <= 1'b0;
      prio         <= 1'b0;
      read_pending <= 1'b0;
      owner        <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          // Counter stops at the terminal address instead of wrapping.
          if (init_addr == '1) begin
            state     <= ARB;
            init_done <= 1'b1;
          end else begin
            init_addr <= init_addr + 1'b1;
          end
        end
        ARB: begin
          read_pending <= 1'b0;
          if (req0_ready) begin
            prio         <= 1'b1;
            read_pending <= ~req0_we;
            owner        <= 1'b0;
          end else if (req1_ready) begin
            prio         <= 1'b0;
            read_pending <= ~req1_we;
            owner        <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // ram_q already holds the word addressed at the grant edge.
  assign rsp0_valid = read_pending & ~owner;
  assign rsp1_valid = read_pending & owner;
  assign rsp0_rdata = rsp0_valid ? ram_q : '0;
  assign rsp1_rdata = rsp1_valid ? ram_q : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
// Directed bench for ram_port_arbiter with a behavioural 64 x 8 RAM,
// a shadow memory / grant model and per-requester response queues.
module tb_ram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_we, req1_valid, req1_we;
  logic [5:0] req0_addr, req1_addr;
  logic [7:0] req0_wdata, req1_wdata;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic [7:0] ram_data, ram_q;
  logic [5:0] ram_addr;
  logic       ram_we, init_done;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_q(ram_q), .init_done(init_done)
  );

  // Behavioural single-port RAM, seeded with non-zero junk so the
  // zero-fill is observable.
  logic [7:0] mem [64];
  logic       mem_seeded = 1'b0;
  always @(posedge clk) begin
    if (!mem_seeded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'hEE ^ 8'(i);
      mem_seeded <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_data;
    end
    ram_q <= mem[ram_addr];
  end

  // Model state
  int         n_tests = 0;
  int         n_fail  = 0;
  logic       m_init;
  int         m_cnt;
  logic       m_prio;
  logic [7:0] shadow [64];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] obs_rsp0, obs_rsp1;
  logic       obs_rsp1v, obs_rdy0, obs_rdy1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1'b1;
    m_cnt  = 0;
    m_prio = 1'b0;
    q0.delete();
    q1.delete();
    for (int i = 0; i < 64; i++) shadow[i] = 8'h00;
  endtask

  task automatic idle();
    req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
  endtask

  task automatic set0(input logic v, input logic we, input logic [5:0] a, input logic [7:0] d);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask

  task automatic set1(input logic v, input logic we, input logic [5:0] a, input logic [7:0] d);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  // Mid-cycle check of everything the model predicts, then model update.
  task automatic check_cycle();
    logic [1:0] g;
    logic       n, we;
    logic [5:0] a;
    logic [7:0] d, e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("rsp0_valid", 32'(rsp0_valid), 32'(1));
      chk("rsp0_rdata", 32'(rsp0_rdata), 32'(e));
    end else begin
      chk("rsp0_idle_valid", 32'(rsp0_valid), 32'(0));
      chk("rsp0_idle_rdata", 32'(rsp0_rdata), 32'(0));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("rsp1_valid", 32'(rsp1_valid), 32'(1));
      chk("rsp1_rdata", 32'(rsp1_rdata), 32'(e));
    end else begin
      chk("rsp1_idle_valid", 32'(rsp1_valid), 32'(0));
      chk("rsp1_idle_rdata", 32'(rsp1_rdata), 32'(0));
    end
    obs_rsp0 = rsp0_rdata; obs_rsp1 = rsp1_rdata; obs_rsp1v = rsp1_valid;
    obs_rdy0 = req0_ready; obs_rdy1 = req1_ready;
    if (m_init) begin
      chk("init_done_low", 32'(init_done), 32'(0));
      chk("init_ready0", 32'(req0_ready), 32'(0));
      chk("init_ready1", 32'(req1_ready), 32'(0));
      chk("init_ram_we", 32'(ram_we), 32'(1));
      chk("init_ram_addr", 32'(ram_addr), 32'(m_cnt));
      chk("init_ram_data", 32'(ram_data), 32'(0));
      if (m_cnt == 63) m_init = 1'b0;
      else m_cnt++;
    end else begin
      chk("init_done_high", 32'(init_done), 32'(1));
      g = 2'b00;
      if (req0_valid && req1_valid) g = m_prio ? 2'b10 : 2'b01;
      else if (req0_valid) g = 2'b01;
      else if (req1_valid) g = 2'b10;
      chk("ready0", 32'(req0_ready), 32'(g[0]));
      chk("ready1", 32'(req1_ready), 32'(g[1]));
      if (g == 2'b00) begin
        chk("idle_ram_we", 32'(ram_we), 32'(0));
        chk("idle_ram_addr", 32'(ram_addr), 32'(0));
        chk("idle_ram_data", 32'(ram_data), 32'(0));
      end else begin
        n  = g[1];
        we = n ? req1_we : req0_we;
        a  = n ? req1_addr : req0_addr;
        d  = n ? req1_wdata : req0_wdata;
        chk("ram_we", 32'(ram_we), 32'(we));
        chk("ram_addr", 32'(ram_addr), 32'(a));
        chk("ram_data", 32'(ram_data), 32'(d));
        if (we) shadow[a] = d;
        else if (n) q1.push_back(shadow[a]);
        else q0.push_back(shadow[a]);
        m_prio = ~n;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_init();
    repeat (64) cycle();
    chk("init_done_after_64", 32'(init_done), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] rdy0_hist, rdy1_hist;

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_init_done", 32'(init_done), 32'(0));
    chk("rst_ready0", 32'(req0_ready), 32'(0));
    chk("rst_ready1", 32'(req1_ready), 32'(0));
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'(0));
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'(0));
    chk("rst_rsp0_rdata", 32'(rsp0_rdata), 32'(0));
    chk("rst_ram_we", 32'(ram_we), 32'(1));
    chk("rst_ram_addr", 32'(ram_addr), 32'(0));
    chk("rst_ram_data", 32'(ram_data), 32'(0));
    rst = 1'b0;
    run_init();

    // Read of the top address after zero-fill
    set0(1, 0, 6'h3F, 8'h00); cycle();
    idle(); cycle();
    chk("read_3f", 32'(obs_rsp0), 32'(8'h00));

    // Single requester back-to-back writes then reads
    set0(1, 1, 6'd0, 8'h01); cycle(); chk("single_rdy_w0", 32'(obs_rdy0), 32'(1));
    set0(1, 1, 6'd1, 8'h02); cycle(); chk("single_rdy_w1", 32'(obs_rdy0), 32'(1));
    set0(1, 1, 6'd3, 8'h03); cycle(); chk("single_rdy_w3", 32'(obs_rdy0), 32'(1));
    set0(1, 0, 6'd0, 8'h00); cycle(); chk("single_rdy_r0", 32'(obs_rdy0), 32'(1));
    set0(1, 0, 6'd1, 8'h00); cycle(); chk("single_rsp_a0", 32'(obs_rsp0), 32'(8'h01));
    set0(1, 0, 6'd2, 8'h00); cycle(); chk("single_rsp_a1", 32'(obs_rsp0), 32'(8'h02));
    idle(); cycle(); chk("single_rsp_a2", 32'(obs_rsp0), 32'(8'h00));

    // Overlap of a response with the next grants
    set0(1, 0, 6'd1, 8'h00); cycle();
    idle(); set1(1, 1, 6'd1, 8'h77); cycle();
    chk("overlap_rsp_old", 32'(obs_rsp0), 32'(8'h02));
    chk("overlap_rsp1v_a", 32'(obs_rsp1v), 32'(0));
    idle(); set0(1, 0, 6'd1, 8'h00); cycle();
    chk("overlap_rsp1v_b", 32'(obs_rsp1v), 32'(0));
    idle(); cycle();
    chk("overlap_rsp_new", 32'(obs_rsp0), 32'(8'h77));
    chk("overlap_rsp1v_c", 32'(obs_rsp1v), 32'(0));

    // Lone req1 read moves prio back to 0
    set1(1, 0, 6'd0, 8'h00); cycle();
    idle(); cycle();
    chk("lone_req1_rsp", 32'(obs_rsp1), 32'(8'h01));

    // Withdrawn request: req1 loses, drops valid, prio keeps req0's update
    set0(1, 1, 6'd10, 8'h55); set1(1, 0, 6'd10, 8'h00); cycle();
    chk("wd_rdy0", 32'(obs_rdy0), 32'(1));
    chk("wd_rdy1", 32'(obs_rdy1), 32'(0));
    idle(); cycle();
    chk("wd_no_rsp1", 32'(obs_rsp1v), 32'(0));
    set0(1, 0, 6'd10, 8'h00); set1(1, 0, 6'd10, 8'h00); cycle();
    chk("wd_prio_rdy1", 32'(obs_rdy1), 32'(1));
    chk("wd_prio_rdy0", 32'(obs_rdy0), 32'(0));
    set1(0, 0, 6'd0, 8'h00); cycle();
    chk("wd_rsp1_data", 32'(obs_rsp1), 32'(8'h55));
    idle(); cycle();
    chk("wd_rsp0_data", 32'(obs_rsp0), 32'(8'h55));
    set1(1, 0, 6'd0, 8'h00); cycle();
    idle(); cycle();

    // Contention with prio = 0: grants alternate 0,1,0,1
    set0(1, 1, 6'd5, 8'hA5); set1(1, 0, 6'd5, 8'h00); cycle();
    rdy0_hist[0] = obs_rdy0; rdy1_hist[0] = obs_rdy1;
    set0(1, 0, 6'd5, 8'h00); cycle();
    rdy0_hist[1] = obs_rdy0; rdy1_hist[1] = obs_rdy1;
    set1(1, 0, 6'd5, 8'h00); cycle();
    rdy0_hist[2] = obs_rdy0; rdy1_hist[2] = obs_rdy1;
    chk("cont_rsp1_a5", 32'(obs_rsp1), 32'(8'hA5));
    set0(1, 0, 6'd5, 8'h00); cycle();
    rdy0_hist[3] = obs_rdy0; rdy1_hist[3] = obs_rdy1;
    chk("cont_rsp0_a5", 32'(obs_rsp0), 32'(8'hA5));
    chk("cont_rdy0_seq", 32'(rdy0_hist), 32'(4'b0101));
    chk("cont_rdy1_seq", 32'(rdy1_hist), 32'(4'b1010));
    idle(); cycle();
    chk("cont_rsp1_last", 32'(obs_rsp1), 32'(8'hA5));
    cycle();

    // Reset asserted while a read response is live and another read is granted
    set0(1, 0, 6'd1, 8'h00); cycle();
    @(negedge clk);
    chk("mid_rsp0_before", 32'(rsp0_valid), 32'(1));
    chk("mid_rdata_before", 32'(rsp0_rdata), 32'(8'h77));
    chk("mid_ready0_before", 32'(req0_ready), 32'(1));
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rsp0_async", 32'(rsp0_valid), 32'(0));
    chk("mid_rdata_async", 32'(rsp0_rdata), 32'(0));
    chk("mid_ready0_async", 32'(req0_ready), 32'(0));
    chk("mid_init_done", 32'(init_done), 32'(0));
    @(posedge clk);
    #1;
    chk("mid_rsp0_after_edge", 32'(rsp0_valid), 32'(0));
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_init();
    set0(1, 0, 6'd1, 8'h00); cycle();
    idle(); cycle();
    chk("mid_reread_zero", 32'(obs_rsp0), 32'(8'h00));
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
